// File: rtl/sdes_pkg.sv
// Shared types, widths and bus-word packing for the S-DES loader.
package sdes_pkg;

  localparam int unsigned BLOCK_W = 8;
  localparam int unsigned KEY_W   = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_SETTLE,
    ST_RESP
  } state_t;

  localparam logic [1:0] STAGE_DATA = 2'd0;
  localparam logic [1:0] STAGE_KEY  = 2'd1;
  localparam logic [1:0] STAGE_MODE = 2'd2;

  typedef struct packed {
    logic [0:BLOCK_W-1] data;
    logic [0:KEY_W-1]   key;
    logic               enc;
  } req_t;

  // Word presented to the front end for a given stage; bit 0 is leftmost.
  function automatic logic [0:KEY_W-1] bus_word(input logic [1:0] stage, input req_t req);
    logic [0:KEY_W-1] word;
    word = '0;
    case (stage)
      STAGE_DATA: word = {req.data, 2'b00};
      STAGE_KEY:  word = req.key;
      STAGE_MODE: word = {req.enc, 9'b0};
      default:    word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/sdes_loader_if.sv
// Request/response handshake and front-end bus between host logic and the loader.
interface sdes_loader_if;
  import sdes_pkg::*;

  logic                 ReqValid;
  logic                 ReqReady;
  logic [0:BLOCK_W-1]   ReqData;
  logic [0:KEY_W-1]     ReqKey;
  logic                 ReqEnc;
  logic [0:KEY_W-1]     BusData;
  logic                 BusSelect;
  logic [0:BLOCK_W-1]   BusResult;
  logic                 RspValid;
  logic [0:BLOCK_W-1]   RspData;
  logic                 RspReady;

  modport master (
    output ReqValid, ReqData, ReqKey, ReqEnc, RspReady, BusResult,
    input  ReqReady, BusData, BusSelect, RspValid, RspData
  );

  modport slave (
    input  ReqValid, ReqData, ReqKey, ReqEnc, RspReady, BusResult,
    output ReqReady, BusData, BusSelect, RspValid, RspData
  );

endinterface

// File: rtl/sdes_phase_timer.sv
// Loadable down-counter; done_c is high while the count sits at zero.
module sdes_phase_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/sdes_loader.sv
// Sequences one request into the data/key/mode strobe protocol and returns the cipher result.
module sdes_loader
  import sdes_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  sdes_loader_if.slave bus
);

  localparam int unsigned MAX_AB  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_CD  = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_t           state;
  logic [1:0]       stage;
  req_t             req_q;
  req_t             req_in;
  logic [1:0]       stage_nxt;
  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             tmr_done_c;

  assign req_in    = '{data: bus.ReqData, key: bus.ReqKey, enc: bus.ReqEnc};
  assign stage_nxt = 2'(stage + 2'd1);
  assign bus.ReqReady = (state == ST_IDLE);

  // Each phase loads its own length minus one on the edge that enters it.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    case (state)
      ST_IDLE: begin
        tmr_load_c = bus.ReqValid;
        tmr_val_c  = CNT_W'(SETUP_CYCLES - 1);
      end
      ST_SETUP: begin
        tmr_load_c = tmr_done_c;
        tmr_val_c  = CNT_W'(PULSE_CYCLES - 1);
      end
      ST_PULSE: begin
        tmr_load_c = tmr_done_c;
        tmr_val_c  = CNT_W'(GAP_CYCLES - 1);
      end
      ST_GAP: begin
        tmr_load_c = tmr_done_c;
        tmr_val_c  = (stage == STAGE_MODE) ? CNT_W'(SETTLE_CYCLES - 1)
                                           : CNT_W'(SETUP_CYCLES - 1);
      end
      default: begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
      end
    endcase
  end

  sdes_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      stage         <= STAGE_DATA;
      req_q         <= '0;
      bus.BusData   <= '0;
      bus.BusSelect <= 1'b0;
      bus.RspValid  <= 1'b0;
      bus.RspData   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ReqValid) begin
            req_q       <= req_in;
            stage       <= STAGE_DATA;
            bus.BusData <= bus_word(STAGE_DATA, req_in);
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done_c) begin
            bus.BusSelect <= 1'b1;
            state         <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tmr_done_c) begin
            bus.BusSelect <= 1'b0;
            state         <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_done_c) begin
            if (stage == STAGE_MODE) begin
              state <= ST_SETTLE;
            end else begin
              stage       <= stage_nxt;
              bus.BusData <= bus_word(stage_nxt, req_q);
              state       <= ST_SETUP;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_done_c) begin
            bus.RspData  <= bus.BusResult;
            bus.RspValid <= 1'b1;
            bus.BusData  <= '0;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.RspReady) begin
            bus.RspValid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_loader.sv
// Bench: two loaders (default and 1/1/1/1 timing) each driving a modelled front end and S-DES cipher.
module tb_sdes_loader;
  import sdes_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;
  logic rcv_rst;
  always #5 CLK = ~CLK;

  localparam int S0_TAB [16] = '{1,0,3,2, 3,2,1,0, 0,2,1,3, 3,1,3,2};
  localparam int S1_TAB [16] = '{0,1,2,3, 2,0,1,3, 3,0,1,0, 2,1,0,3};

  sdes_loader_if ifc0 ();
  sdes_loader_if ifc1 ();

  sdes_loader dut0 (.CLK(CLK), .RST_N(RST_N), .bus(ifc0.slave));
  sdes_loader #(.SETUP_CYCLES(1), .PULSE_CYCLES(1), .GAP_CYCLES(1), .SETTLE_CYCLES(1))
    dut1 (.CLK(CLK), .RST_N(RST_N), .bus(ifc1.slave));

  logic       req_valid [2];
  logic       rsp_ready [2];
  logic [0:7] req_data;
  logic [0:9] req_key;
  logic       req_enc;

  assign ifc0.ReqValid = req_valid[0];
  assign ifc1.ReqValid = req_valid[1];
  assign ifc0.RspReady = rsp_ready[0];
  assign ifc1.RspReady = rsp_ready[1];
  assign ifc0.ReqData  = req_data;
  assign ifc1.ReqData  = req_data;
  assign ifc0.ReqKey   = req_key;
  assign ifc1.ReqKey   = req_key;
  assign ifc0.ReqEnc   = req_enc;
  assign ifc1.ReqEnc   = req_enc;

  logic       o_req_ready [2];
  logic [0:9] o_bus_data  [2];
  logic       o_bus_sel   [2];
  logic       o_rsp_valid [2];
  logic [0:7] o_rsp_data  [2];
  assign o_req_ready[0] = ifc0.ReqReady;   assign o_req_ready[1] = ifc1.ReqReady;
  assign o_bus_data[0]  = ifc0.BusData;    assign o_bus_data[1]  = ifc1.BusData;
  assign o_bus_sel[0]   = ifc0.BusSelect;  assign o_bus_sel[1]   = ifc1.BusSelect;
  assign o_rsp_valid[0] = ifc0.RspValid;   assign o_rsp_valid[1] = ifc1.RspValid;
  assign o_rsp_data[0]  = ifc0.RspData;    assign o_rsp_data[1]  = ifc1.RspData;

  // ---------------- S-DES reference ----------------
  function automatic logic [0:7] p8(input logic [0:9] t);
    return {t[5], t[2], t[6], t[3], t[7], t[4], t[9], t[8]};
  endfunction

  function automatic logic [0:7] fk(input logic [0:7] v, input logic [0:7] sk);
    logic [0:3] r;
    logic [0:7] ep;
    logic [1:0] s0v, s1v;
    logic [0:3] y;
    r   = v[4:7];
    ep  = {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]} ^ sk;
    s0v = 2'(S0_TAB[int'({ep[0], ep[3]}) * 4 + int'({ep[1], ep[2]})]);
    s1v = 2'(S1_TAB[int'({ep[4], ep[7]}) * 4 + int'({ep[5], ep[6]})]);
    y   = {s0v, s1v};
    return {v[0:3] ^ {y[1], y[3], y[2], y[0]}, r};
  endfunction

  function automatic logic [0:7] sdes(input logic [0:7] pt, input logic [0:9] key, input logic enc);
    logic [0:9] p10, ls1, ls3;
    logic [0:7] k1, k2, x;
    p10 = {key[2], key[4], key[1], key[6], key[3], key[9], key[0], key[8], key[7], key[5]};
    ls1 = {p10[1:4], p10[0], p10[6:9], p10[5]};
    ls3 = {ls1[2:4], ls1[0:1], ls1[7:9], ls1[5:6]};
    k1  = p8(ls1);
    k2  = p8(ls3);
    x   = {pt[1], pt[5], pt[2], pt[0], pt[3], pt[7], pt[4], pt[6]};
    x   = fk(x, enc ? k1 : k2);
    x   = {x[4:7], x[0:3]};
    x   = fk(x, enc ? k2 : k1);
    return {x[3], x[0], x[2], x[4], x[6], x[1], x[7], x[5]};
  endfunction

  // ---------------- front-end receiver model ----------------
  logic [1:0] rcv_ptr    [2];
  logic       rcv_prev   [2];
  logic [0:7] rcv_data   [2];
  logic [0:9] rcv_key    [2];
  logic       rcv_mode   [2];
  int         strobe_cnt [2];

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (rcv_rst) begin
        rcv_ptr[i]  <= 2'd0;
        rcv_prev[i] <= 1'b0;
      end else begin
        rcv_prev[i] <= o_bus_sel[i];
        if (o_bus_sel[i] && !rcv_prev[i]) begin
          strobe_cnt[i] <= strobe_cnt[i] + 1;
          case (rcv_ptr[i])
            2'd0:    rcv_data[i] <= o_bus_data[i][0:7];
            2'd1:    rcv_key[i]  <= o_bus_data[i];
            default: rcv_mode[i] <= o_bus_data[i][0];
          endcase
          rcv_ptr[i] <= (rcv_ptr[i] == 2'd2) ? 2'd0 : 2'(rcv_ptr[i] + 2'd1);
        end
      end
    end
  end

  assign ifc0.BusResult = sdes(rcv_data[0], rcv_key[0], rcv_mode[0]);
  assign ifc1.BusResult = sdes(rcv_data[1], rcv_key[1], rcv_mode[1]);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int su(input int sel);  return sel == 0 ? 2 : 1; endfunction
  function automatic int pu(input int sel);  return sel == 0 ? 2 : 1; endfunction
  function automatic int gp(input int sel);  return sel == 0 ? 2 : 1; endfunction
  function automatic int stl(input int sel); return sel == 0 ? 4 : 1; endfunction

  logic [0:7] last_rsp;

  // Full transaction with cycle-exact expectations derived from the phase lengths.
  task automatic run_req(input int sel, input logic [0:7] d, input logic [0:9] k, input logic e,
                         input int hold, input bit poke);
    int p, lat, s0, kst, r;
    logic [0:9] w [3];
    logic [0:7] exp_rsp;
    logic       exp_sel;
    p   = su(sel) + pu(sel) + gp(sel);
    lat = 3 * p + stl(sel);
    w[0] = {d, 2'b00};
    w[1] = k;
    w[2] = {e, 9'b0};
    exp_rsp = sdes(d, k, e);
    check("idle_ready", 32'(o_req_ready[sel]), 32'd1);
    req_data = d; req_key = k; req_enc = e;
    req_valid[sel] = 1'b1;
    rsp_ready[sel] = (hold == 0);
    s0 = strobe_cnt[sel];
    step();
    req_valid[sel] = 1'b0;
    for (int n = 0; n <= lat; n++) begin
      if (n < lat) begin
        kst = (n < 3 * p) ? n / p : 2;
        r   = n % p;
        exp_sel = (n < 3 * p) && (r >= su(sel)) && (r < su(sel) + pu(sel));
        check("bus_sel", 32'(o_bus_sel[sel]), 32'(exp_sel));
        check("bus_data", 32'(o_bus_data[sel]), 32'(w[kst]));
        check("rsp_valid_early", 32'(o_rsp_valid[sel]), 32'd0);
        check("busy_ready", 32'(o_req_ready[sel]), 32'd0);
        if (poke) req_valid[sel] = ((n % 5) == 3);
        step();
      end else begin
        req_valid[sel] = 1'b0;
        check("rsp_valid", 32'(o_rsp_valid[sel]), 32'd1);
        check("rsp_data", 32'(o_rsp_data[sel]), 32'(exp_rsp));
        check("resp_bus_data", 32'(o_bus_data[sel]), 32'd0);
        check("strobes", 32'(strobe_cnt[sel] - s0), 32'd3);
      end
    end
    last_rsp = o_rsp_data[sel];
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) req_valid[sel] = 1'b1;
      step();
      check("hold_valid", 32'(o_rsp_valid[sel]), 32'd1);
      check("hold_data", 32'(o_rsp_data[sel]), 32'(exp_rsp));
      check("hold_ready", 32'(o_req_ready[sel]), 32'd0);
      check("hold_sel", 32'(o_bus_sel[sel]), 32'd0);
    end
    req_valid[sel] = 1'b0;
    rsp_ready[sel] = 1'b1;
    step();
    check("rsp_clear", 32'(o_rsp_valid[sel]), 32'd0);
    check("ready_back", 32'(o_req_ready[sel]), 32'd1);
    check("no_extra_strobes", 32'(strobe_cnt[sel] - s0), 32'd3);
    rsp_ready[sel] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:7] rd;
    logic [0:9] rk;
    int p0;
    RST_N = 1'b0;
    rcv_rst = 1'b1;
    req_valid = '{1'b0, 1'b0};
    rsp_ready = '{1'b0, 1'b0};
    strobe_cnt = '{0, 0};
    req_data = '0; req_key = '0; req_enc = 1'b0;
    repeat (3) step();
    RST_N = 1'b1;
    rcv_rst = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(o_req_ready[i]), 32'd1);
      check("rst_sel", 32'(o_bus_sel[i]), 32'd0);
      check("rst_bus_data", 32'(o_bus_data[i]), 32'd0);
      check("rst_rsp_valid", 32'(o_rsp_valid[i]), 32'd0);
      check("rst_rsp_data", 32'(o_rsp_data[i]), 32'd0);
    end

    run_req(0, 8'b10010111, 10'b1010000010, 1'b1, 0, 1'b0);
    check("enc_vector", 32'(last_rsp), 32'(8'b00111000));
    run_req(0, 8'b00111000, 10'b1010000010, 1'b0, 10, 1'b1);
    check("dec_vector", 32'(last_rsp), 32'(8'b10010111));
    run_req(1, 8'b10010111, 10'b1010000010, 1'b1, 0, 1'b0);
    check("fast_enc_vector", 32'(last_rsp), 32'(8'b00111000));

    // Abort during the stage-1 pulse.
    p0 = su(0) + pu(0) + gp(0);
    req_data = 8'hA5; req_key = 10'h2C3; req_enc = 1'b1;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    for (int n = 0; n < p0 + su(0); n++) step();
    check("mid_pulse_sel", 32'(o_bus_sel[0]), 32'd1);
    RST_N = 1'b0;
    step();
    check("abort_sel", 32'(o_bus_sel[0]), 32'd0);
    check("abort_bus_data", 32'(o_bus_data[0]), 32'd0);
    check("abort_ready", 32'(o_req_ready[0]), 32'd1);
    RST_N = 1'b1;
    rcv_rst = 1'b1;
    step();
    rcv_rst = 1'b0;
    run_req(0, 8'b11001010, 10'b0111001101, 1'b1, 1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rd = 8'($urandom);
      rk = 10'($urandom);
      run_req(int'($urandom_range(0, 1)), rd, rk, 1'($urandom), int'($urandom_range(0, 3)),
              1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
